// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one LED among NREQ requesters, each granted a burst of blinks.
// Define LED_FIXED_PRIORITY_EN to replace round-robin with fixed priority (req[0] highest).
module led_blink_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned BLINK_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BLINK_W-1:0] blinks,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic                    busy,
  output logic                    LED
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ON   = 3'd1,
    S_OFF  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   presc;
  logic [BLINK_W-1:0] remaining;
  logic [IDX_W-1:0]   cur;

  logic               req_any;
  logic [IDX_W-1:0]   win;
  logic [BLINK_W-1:0] win_blinks;
  logic [BLINK_W-1:0] rem_dec;
  logic               phase_end;
  logic               cur_req;

`ifdef LED_FIXED_PRIORITY_EN
  // Lowest-index active request wins.
  always_comb begin
    win     = '0;
    req_any = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!req_any && req[i]) begin
        win     = IDX_W'(i);
        req_any = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] cand;

  // First active request searching upward from the slot after the last winner.
  always_comb begin
    win     = '0;
    req_any = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IDX_W'((int'(last_winner) + k) % int'(NREQ));
      if (!req_any && req[cand]) begin
        win     = cand;
        req_any = 1'b1;
      end
    end
  end
`endif

  assign win_blinks = blinks[int'(win)*int'(BLINK_W) +: BLINK_W];
  assign rem_dec    = (remaining != '0) ? remaining - BLINK_W'(1) : '0;
  assign phase_end  = (presc == PHASE_LAST);
  assign cur_req    = req[cur];
  assign busy       = (state != S_IDLE);

  // Arbitration and ON/OFF/GAP sequencing; LED, gnt and done are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      presc       <= '0;
      remaining   <= '0;
      cur         <= '0;
      gnt         <= '0;
      done        <= 1'b0;
      LED         <= 1'b0;
`ifndef LED_FIXED_PRIORITY_EN
      last_winner <= IDX_W'(NREQ - 1);
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            cur       <= win;
            gnt       <= NREQ'(1) << win;
            remaining <= win_blinks;
            presc     <= '0;
            if (win_blinks != '0) begin
              state <= S_ON;
              LED   <= 1'b1;
            end else begin
              state <= S_GAP;
              LED   <= 1'b0;
            end
          end
        end

        S_ON: begin
          if (!cur_req) begin
            state <= S_GAP;
            LED   <= 1'b0;
            presc <= '0;
          end else if (phase_end) begin
            state <= S_OFF;
            LED   <= 1'b0;
            presc <= '0;
          end else begin
            presc <= presc + CNT_W'(1);
          end
        end

        S_OFF: begin
          if (!cur_req) begin
            state <= S_GAP;
            LED   <= 1'b0;
            presc <= '0;
          end else if (phase_end) begin
            remaining <= rem_dec;
            presc     <= '0;
            if (rem_dec != '0) begin
              state <= S_ON;
              LED   <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end else begin
            presc <= presc + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (phase_end) begin
            state <= S_DONE;
            done  <= 1'b1;
            presc <= '0;
          end else begin
            presc <= presc + CNT_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          presc <= '0;
`ifndef LED_FIXED_PRIORITY_EN
          last_winner <= cur;
`endif
        end

        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          LED   <= 1'b0;
          presc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with CLK_DIV=4, NREQ=4, BLINK_W=4.
module tb_led_blink_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BLINK_W = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req;
  logic [NREQ*BLINK_W-1:0] blinks;
  logic [NREQ-1:0]         gnt;
  logic                    done;
  logic                    busy;
  logic                    LED;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_blink_arbiter #(
    .NREQ(NREQ), .CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .BLINK_W(BLINK_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .blinks(blinks),
    .gnt(gnt), .done(done), .busy(busy), .LED(LED)
  );

  // Cycle k is the interval after the k-th rising edge following reset release.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n  = 1'b1;
    #1;
    rst_n  = 1'b0;
    req    = '0;
    blinks = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    rst_n  = 1'b1;
    #1;
    rst_n  = 1'b0;
    req    = 4'b1111;
    blinks = 16'h1111;
    #1;
    obs = {gnt, LED, done, busy};
    n_cmp++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_async got %b want %b (gnt,led,done,busy)", obs, 7'b0);
    end
    repeat (3) begin
      tick();
      obs = {gnt, LED, done, busy};
      n_cmp++;
      if (obs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_held got %b want %b (gnt,led,done,busy)", obs, 7'b0);
      end
    end
    req    = '0;
    blinks = '0;
    #2;
    rst_n  = 1'b1;
  endtask

  // req=0010, blinks[1]=2: grant cycles 1-21, LED 1-4 and 9-12, done at 21.
  task automatic test_single;
    logic [6:0] obs, exp;
    logic       led_e;
    do_reset();
    req        = 4'b0010;
    blinks[7:4] = 4'd2;
    for (int c = 1; c <= 22; c++) begin
      tick();
      led_e = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
      exp   = {(c <= 21) ? 4'b0010 : 4'b0000, led_e, c == 21, c <= 21};
      obs   = {gnt, LED, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL single c=%0d got %b want %b (gnt,led,done,busy)", c, obs, exp);
      end
      if (c == 21) req = '0;
    end
  endtask

  // req=1111, all blinks=1: 13-cycle grants separated by one idle cycle.
  task automatic test_round_robin;
    logic [6:0] obs, exp;
    logic [3:0] g_e;
    int         g, pos;
    do_reset();
    req    = 4'b1111;
    blinks = 16'h1111;
    for (int c = 1; c <= 70; c++) begin
      tick();
      g   = (c - 1) / 14;
      pos = (c - 1) % 14;
`ifdef LED_FIXED_PRIORITY_EN
      g_e = 4'b0001;
`else
      g_e = 4'b0001 << (g % 4);
`endif
      if (pos < 13 && c < 70)
        exp = {g_e, pos < 4, pos == 12, 1'b1};
      else
        exp = 7'b0;
      obs = {gnt, LED, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL round_robin c=%0d got %b want %b (gnt,led,done,busy)", c, obs, exp);
      end
      if (c == 69) req = '0;
    end
  endtask

  // req=0100, blinks[2]=0: GAP only, grant cycles 1-5, done at 5.
  task automatic test_zero_count;
    logic [6:0] obs, exp;
    do_reset();
    req          = 4'b0100;
    blinks[11:8] = 4'd0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp = {(c <= 5) ? 4'b0100 : 4'b0000, 1'b0, c == 5, c <= 5};
      obs = {gnt, LED, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL zero_count c=%0d got %b want %b (gnt,led,done,busy)", c, obs, exp);
      end
      if (c == 5) req = '0;
    end
  endtask

  // req[0] drops in cycle 2: GAP cycles 3-6, done at 7, idle at 8.
  task automatic test_abort;
    logic [6:0] obs, exp;
    do_reset();
    req         = 4'b0001;
    blinks[3:0] = 4'd3;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = {(c <= 7) ? 4'b0001 : 4'b0000, c <= 2, c == 7, c <= 7};
      obs = {gnt, LED, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL abort c=%0d got %b want %b (gnt,led,done,busy)", c, obs, exp);
      end
      if (c == 2) req = '0;
    end
  endtask

  // Async reset in OFF, then a full restart of the same 2-blink burst.
  task automatic test_reset_mid_burst;
    logic [6:0] obs, exp;
    logic       led_e;
    do_reset();
    req         = 4'b0001;
    blinks[3:0] = 4'd2;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    obs = {gnt, LED, done, busy};
    n_cmp++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async got %b want %b (gnt,led,done,busy)", obs, 7'b0);
    end
    repeat (2) begin
      tick();
      obs = {gnt, LED, done, busy};
      n_cmp++;
      if (obs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_mid_held got %b want %b (gnt,led,done,busy)", obs, 7'b0);
      end
    end
    #2;
    rst_n = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      led_e = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
      exp   = {(c <= 21) ? 4'b0001 : 4'b0000, led_e, c == 21, c <= 21};
      obs   = {gnt, LED, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_restart c=%0d got %b want %b (gnt,led,done,busy)", c, obs, exp);
      end
      if (c == 21) req = '0;
    end
  endtask

  // blinks[1] drops 3->1 after the grant; captured count of 3 still applies.
  task automatic test_blinks_change;
    logic [6:0] obs, exp;
    logic       led_e;
    do_reset();
    req         = 4'b0010;
    blinks[7:4] = 4'd3;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) blinks[7:4] = 4'd1;
      led_e = (c <= 24) && (((c - 1) % 8) < 4);
      exp   = {(c <= 29) ? 4'b0010 : 4'b0000, led_e, c == 29, c <= 29};
      obs   = {gnt, LED, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL blinks_change c=%0d got %b want %b (gnt,led,done,busy)", c, obs, exp);
      end
      if (c == 29) req = '0;
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    req    = '0;
    blinks = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_count();
    test_abort();
    test_reset_mid_burst();
    test_blinks_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
